fetch_req_queue: RTL and testbench
==================================

FETCH_REQ_QUEUE -- requirements
Module: fetch_req_queue

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width.
REQ-002 Parameter MAX_OUT, default 4, max in-flight instruction requests (power of 2, >=1).
REQ-003 Parameter IBUF_DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-004 Parameter RESET_PC, default 32'h1C000000, fetch PC after reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 redirect_valid  input  1  flush pipeline and restart fetch at redirect_pc (branch/exception/ertn).
REQ-008 redirect_pc  input  ADDR_W  new fetch PC.
REQ-009 inst_req  output  1  request to instruction memory.
REQ-010 inst_addr  output  ADDR_W  request address (= current fetch PC).
REQ-011 inst_addr_ok  input  1  request accepted this cycle when inst_req=1.
REQ-012 inst_data_ok  input  1  one response returned, in request order.
REQ-013 inst_rdata  input  32  response instruction.
REQ-014 out_valid  output  1  buffer head valid to decode.
REQ-015 out_ready  input  1  decode accepts head.
REQ-016 out_pc  output  ADDR_W  PC of head entry.
REQ-017 out_inst  output  32  instruction of head entry (0 when out_adef=1).
REQ-018 out_adef  output  1  head entry is a fetch-address-misalignment exception.

Function
REQ-019 State SHALL be: fetch PC, inflight counter (0..MAX_OUT), discard counter (<=inflight), PC FIFO of MAX_OUT entries for non-discarded in-flight requests, IBUF of IBUF_DEPTH {pc,inst,adef} entries, halt flag.
REQ-020 inst_req SHALL be 1 iff: no redirect_valid, halt=0, fetch PC[1:0]=0, inflight<MAX_OUT, and (inflight-discard)+ibuf_count<IBUF_DEPTH.
REQ-021 inst_addr SHALL equal fetch PC combinationally; stable while inst_req=1 without inst_addr_ok.
REQ-022 On inst_req&inst_addr_ok: push fetch PC into PC FIFO, inflight+1, fetch PC+4 (wraps modulo 2^ADDR_W).
REQ-023 On inst_data_ok with discard>0: drop response, discard-1, inflight-1, PC FIFO untouched.
REQ-024 On inst_data_ok with discard=0: pop PC FIFO, push {pc,inst_rdata,0} into IBUF, inflight-1.
REQ-025 Simultaneous addr_ok and data_ok SHALL net inflight unchanged.
REQ-026 data_ok with inflight=0 is a protocol error; SHALL be ignored.
REQ-027 Fetch PC[1:0]!=0 and halt=0: when inflight-discard=0 and IBUF not full, push {PC,0,1} into IBUF and set halt; no memory request issued.
REQ-028 out_valid SHALL be (ibuf_count!=0) & ~redirect_valid; head fields driven from IBUF head.
REQ-029 out_valid&out_ready SHALL pop IBUF head; push and pop in the same cycle SHALL leave count unchanged, including at full.
REQ-030 Latency: data_ok in cycle N -> out_valid in N+1 (no bypass).
REQ-031 On redirect_valid: next cycle fetch PC=redirect_pc, IBUF empty, PC FIFO empty, halt=0, discard=inflight after this cycle's data_ok decrement; a data_ok in the redirect cycle is dropped.
REQ-032 Redirect has priority over every other event in the same cycle; back-to-back redirects SHALL accumulate correctly (discard never exceeds inflight).
REQ-033 Redirect SHALL NOT cancel accepted requests; their responses are always consumed and discarded.

Reset
REQ-034 On reset: fetch PC=RESET_PC, inflight=0, discard=0, FIFOs empty, halt=0; inst_req=1 and out_valid=0 in the first cycle after reset deasserts.
REQ-035 Reset mid-operation SHALL drop all state; responses to pre-reset requests are not the block's responsibility.

Verification
REQ-036 Zero-wait memory, out_ready=1: addr_ok every cycle -> out_pc sequence 1C000000,1C000004,... one per cycle after 2-cycle pipe fill.
REQ-037 out_ready=0 with IBUF_DEPTH=4: exactly 4 requests accepted, inst_req drops to 0; out_ready=1 -> four entries delivered in order, fetch resumes.
REQ-038 3 requests in flight, redirect to 1C000100 -> 3 responses dropped, first out_pc=1C000100 with its own rdata.
REQ-039 Redirect to 1C000102 -> no inst_req, one entry out_adef=1 out_pc=1C000102 out_inst=0, then idle until next redirect.
REQ-040 Redirect coinciding with data_ok and out_valid&out_ready -> that response dropped, out_valid=0 that cycle, discard count = inflight-1.
REQ-041 Random addr_ok/data_ok delays (0-5 cycles), random out_ready and redirects -> delivered PCs strictly sequential between redirects, every inst matches memory model, no loss or duplication.

Source files
------------

// File: rtl/fetch_req_queue.sv
// Instruction fetch front end: issues in-order memory requests and tracks their PCs.
// Collects responses into a small instruction buffer; redirects drain stale responses.
module fetch_req_queue #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       MAX_OUT    = 4,
  parameter int unsigned       IBUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h1C00_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic              out_adef
);

  localparam int unsigned CntW   = $clog2(MAX_OUT + 1);
  localparam int unsigned PtrW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned IbPtrW = $clog2(IBUF_DEPTH);
  localparam int unsigned IbCntW = IbPtrW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic              adef;
  } ibuf_entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]   inflight_q, inflight_d, discard_q, discard_d, live;
  logic              halt_q, halt_d;

  logic [ADDR_W-1:0] pcf_mem [2**PtrW];
  logic [PtrW-1:0]   pcf_wr_q, pcf_rd_q;

  ibuf_entry_t       ibuf_mem [IBUF_DEPTH];
  ibuf_entry_t       ib_wdata;
  logic [IbPtrW-1:0] ib_wr_q, ib_rd_q;
  logic [IbCntW-1:0] ib_cnt_q, ib_cnt_d;

  logic        aligned, ib_full, req_fire, rsp, rsp_drop, rsp_keep, adef_push, ib_push, ib_pop;
  logic [31:0] occupancy;

  // Non-discarded in-flight requests still need an IBUF slot reserved for their response.
  assign live      = inflight_q - discard_q;
  assign occupancy = 32'(live) + 32'(ib_cnt_q);
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign ib_full   = (ib_cnt_q == IbCntW'(IBUF_DEPTH));

  assign inst_req  = ~redirect_valid & ~halt_q & aligned &
                     (inflight_q < CntW'(MAX_OUT)) & (occupancy < IBUF_DEPTH);
  assign inst_addr = pc_q;
  assign req_fire  = inst_req & inst_addr_ok;

  assign rsp       = inst_data_ok & (inflight_q != '0);
  assign rsp_drop  = rsp & (discard_q != '0);
  assign rsp_keep  = rsp & (discard_q == '0) & ~redirect_valid;
  assign adef_push = ~redirect_valid & ~halt_q & ~aligned & (live == '0) & ~ib_full;
  assign ib_push   = rsp_keep | adef_push;

  assign out_valid = (ib_cnt_q != '0) & ~redirect_valid;
  assign ib_pop    = out_valid & out_ready;
  assign out_pc    = ibuf_mem[ib_rd_q].pc;
  assign out_inst  = ibuf_mem[ib_rd_q].inst;
  assign out_adef  = ibuf_mem[ib_rd_q].adef;

  always_comb begin
    ib_wdata = '{pc: pcf_mem[pcf_rd_q], inst: inst_rdata, adef: 1'b0};
    if (adef_push) begin
      ib_wdata = '{pc: pc_q, inst: '0, adef: 1'b1};
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    ib_cnt_d   = ib_cnt_q;
    if (redirect_valid) begin
      // Everything still outstanding becomes a response to throw away.
      pc_d       = redirect_pc;
      inflight_d = inflight_q - CntW'(rsp);
      discard_d  = inflight_d;
      halt_d     = 1'b0;
      ib_cnt_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_W'(4);
      end
      inflight_d = inflight_q + CntW'(req_fire) - CntW'(rsp);
      if (rsp_drop) begin
        discard_d = discard_q - CntW'(1);
      end
      if (adef_push) begin
        halt_d = 1'b1;
      end
      ib_cnt_d = ib_cnt_q + IbCntW'(ib_push) - IbCntW'(ib_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      halt_q     <= 1'b0;
      ib_cnt_q   <= '0;
      ib_wr_q    <= '0;
      ib_rd_q    <= '0;
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
      ib_cnt_q   <= ib_cnt_d;
      if (redirect_valid) begin
        ib_wr_q  <= '0;
        ib_rd_q  <= '0;
        pcf_wr_q <= '0;
        pcf_rd_q <= '0;
      end else begin
        if (req_fire) pcf_wr_q <= pcf_wr_q + PtrW'(1);
        if (rsp_keep) pcf_rd_q <= pcf_rd_q + PtrW'(1);
        if (ib_push)  ib_wr_q  <= ib_wr_q + IbPtrW'(1);
        if (ib_pop)   ib_rd_q  <= ib_rd_q + IbPtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcf_mem[pcf_wr_q] <= pc_q;
    if (ib_push)  ibuf_mem[ib_wr_q] <= ib_wdata;
  end

endmodule

// File: tb/tb_fetch_req_queue.sv
// Self-checking bench for fetch_req_queue: in-order memory model with random latency
// and a scoreboard of expected delivered {pc, inst, adef} entries.
module tb_fetch_req_queue;

  localparam logic [31:0] ResetPc = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;

  fetch_req_queue #(
    .ADDR_W    (32),
    .MAX_OUT   (4),
    .IBUF_DEPTH(4),
    .RESET_PC  (ResetPc)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_adef      (out_adef)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mem_ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } sb_ent_t;

  mem_ent_t mem_q[$];
  sb_ent_t  sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Stimulus knobs
  int          p_addr = 0, p_ready = 0, p_redir = 0, d_min = 0, d_max = 0;
  logic        redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  // Reference state
  logic [31:0] exp_pc = ResetPc;
  logic        exp_halt = 1'b0;
  int          acc_cnt = 0, dlv_cnt = 0, first_acc = -1, first_val = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    sb_ent_t e;
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_now      = 1'b0;
    end else if (p_redir != 0 && $urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1C00_0000 + 32'($urandom_range(255)) * 4 +
                       (($urandom_range(9) == 0) ? 32'd2 : 32'd0);
    end
    inst_data_ok = (mem_q.size() != 0) && (cyc >= mem_q[0].rdy);
    inst_rdata   = inst_data_ok ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    inst_addr_ok = ($urandom_range(99) < p_addr);
    out_ready    = ($urandom_range(99) < p_ready);
    #1;
    if (redirect_valid) begin
      check_eq("redir_out_valid_low", 32'(out_valid), 0);
      check_eq("redir_inst_req_low", 32'(inst_req), 0);
      sb.delete();
      exp_pc   = redirect_pc;
      exp_halt = (redirect_pc[1:0] != 2'b00);
      if (exp_halt) sb.push_back('{pc: redirect_pc, inst: 32'h0, adef: 1'b1});
    end else begin
      if (exp_halt) check_eq("halt_no_req", 32'(inst_req), 0);
      if (inst_req && inst_addr_ok) begin
        check_eq("req_addr", inst_addr, exp_pc);
        mem_q.push_back('{addr: inst_addr, rdy: cyc + 1 + int'($urandom_range(d_max, d_min))});
        sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc), adef: 1'b0});
        exp_pc += 4;
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        dlv_cnt++;
        check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("out_pc", out_pc, e.pc);
          check_eq("out_inst", out_inst, e.inst);
          check_eq("out_adef", 32'(out_adef), 32'(e.adef));
        end
      end
    end
    if (inst_data_ok) void'(mem_q.pop_front());
  endtask

  task automatic drain();
    p_addr  = 0;
    p_redir = 0;
    p_ready = 100;
    for (int i = 0; i < 300 && (sb.size() != 0 || mem_q.size() != 0); i++) step();
    step();
    check_eq("drain_sb_empty", sb.size(), 0);
    check_eq("drain_mem_empty", mem_q.size(), 0);
    check_eq("drain_out_idle", 32'(out_valid), 0);
  endtask

  task automatic clear_stats();
    acc_cnt   = 0;
    dlv_cnt   = 0;
    first_acc = -1;
    first_val = -1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("reset_inst_req", 32'(inst_req), 1);
    check_eq("reset_out_valid", 32'(out_valid), 0);
    check_eq("reset_inst_addr", inst_addr, ResetPc);

    // Zero-wait streaming: two-cycle fill then one entry per cycle
    p_addr = 100; p_ready = 100; d_min = 0; d_max = 0;
    clear_stats();
    repeat (20) step();
    check_eq("fill_latency", 32'(first_val - first_acc), 2);
    check_eq("stream_rate", 32'(dlv_cnt), 18);
    drain();

    // Decode stalled: buffer capacity bounds acceptance
    p_addr = 100; p_ready = 0; d_min = 0; d_max = 0;
    clear_stats();
    repeat (12) step();
    check_eq("stall_accepts", 32'(acc_cnt), 4);
    check_eq("stall_req_low", 32'(inst_req), 0);
    p_ready = 100;
    clear_stats();
    repeat (8) step();
    check_eq("stall_delivered", 32'(dlv_cnt >= 4), 1);
    check_eq("resume_accepts", 32'(acc_cnt >= 4), 1);
    drain();

    // Three slow requests in flight, then redirect
    p_addr = 100; p_ready = 100; d_min = 10; d_max = 10;
    clear_stats();
    repeat (3) step();
    check_eq("inflight_three", 32'(acc_cnt), 3);
    p_addr = 0;
    redir_now = 1'b1; redir_target = 32'h1C00_0100;
    step();
    p_addr = 100; d_min = 0; d_max = 0;
    clear_stats();
    repeat (30) step();
    check_eq("post_redir_delivered", 32'(dlv_cnt > 0), 1);
    drain();

    // Misaligned redirect: one adef entry, then no requests
    redir_now = 1'b1; redir_target = 32'h1C00_0102;
    p_addr = 100; p_ready = 100;
    clear_stats();
    repeat (12) step();
    check_eq("adef_delivered", sb.size(), 0);
    check_eq("adef_count", 32'(dlv_cnt), 1);
    check_eq("adef_no_accepts", 32'(acc_cnt), 0);
    redir_now = 1'b1; redir_target = 32'h1C00_0200;
    repeat (10) step();
    drain();

    // Redirect landing on a cycle with data_ok and a ready head
    p_addr = 100; p_ready = 100; d_min = 0; d_max = 0;
    repeat (10) step();
    redir_now = 1'b1; redir_target = 32'h1C00_0300;
    repeat (15) step();
    drain();

    // Random traffic with random redirects
    p_addr = 60; p_ready = 70; p_redir = 3; d_min = 0; d_max = 5;
    repeat (3000) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
